// File: rtl/encoder_sequencer.sv
// Round/stage sequencer for the encoder datapath: launches the five stage
// controllers in order for NUM_ROUNDS rounds, ping-pongs the memory banks and
// watches each stage with a timeout.
module encoder_sequencer #(
  parameter int NUM_ROUNDS  = 24,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] stage_done,
  output logic [4:0] stage_start,
  output logic [4:0] round,
  output logic       src_sel,
  output logic       dst_sel,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [4:0]  LAST_ROUND = 5'(NUM_ROUNDS - 1);
  localparam logic [15:0] WD_LIMIT   = 16'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  LAST_STAGE = 3'd4;

  state_t      r_state;
  logic [2:0]  r_stage;
  logic [15:0] r_wd;
  logic [4:0]  r_stage_start;
  logic [4:0]  r_round;
  logic        r_src;
  logic        r_dst;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        w_stage_hit;

  // Stage handshake: stage_start[s] is a one-cycle launch pulse; the stage
  // answers with a one-cycle stage_done[s] pulse some cycles later. Only the
  // bit of the stage currently being waited on is honoured.
  assign w_stage_hit = stage_done[r_stage];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_stage       <= '0;
      r_wd          <= '0;
      r_stage_start <= '0;
      r_round       <= '0;
      r_src         <= 1'b0;
      r_dst         <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_stage_start <= '0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_LAUNCH;
            r_round       <= '0;
            r_stage       <= '0;
            r_src         <= 1'b0;
            r_dst         <= 1'b1;
            r_wd          <= '0;
            r_busy        <= 1'b1;
            r_stage_start <= 5'b00001;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
          r_wd    <= '0;
        end
        S_WAIT: begin
          // A completion in the last allowed cycle beats the timeout.
          if (w_stage_hit) begin
            r_state <= S_NEXT;
          end else if (r_wd == WD_LIMIT) begin
            r_state <= S_FAULT;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        S_NEXT: begin
          r_src <= ~r_src;
          r_dst <= r_src;
          if (r_stage < LAST_STAGE) begin
            r_stage       <= r_stage + 3'd1;
            r_state       <= S_LAUNCH;
            r_stage_start <= 5'b00001 << (r_stage + 3'd1);
          end else if (r_round < LAST_ROUND) begin
            r_round       <= r_round + 5'd1;
            r_stage       <= '0;
            r_state       <= S_LAUNCH;
            r_stage_start <= 5'b00001;
          end else begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_FAULT: begin
          // Clearing a fault only returns to IDLE; a new job needs another start.
          if (start) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign stage_start = r_stage_start;
  assign round       = r_round;
  assign src_sel     = r_src;
  assign dst_sel     = r_dst;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_encoder_sequencer.sv
// Directed bench for encoder_sequencer: a 2-round/timeout-8 instance for the
// sequencing, fault and reset cases and a default instance for full latency.
module tb_encoder_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // instance A: NUM_ROUNDS=2, TIMEOUT_CYC=8
  logic       rst_a = 1'b0, start_a = 1'b0;
  logic [4:0] stage_done_a = '0;
  logic [4:0] stage_start_a, round_a;
  logic       src_a, dst_a, busy_a, done_a, err_a;
  logic [2:0] state_a;

  // instance B: default parameters
  logic       rst_b = 1'b0, start_b = 1'b0;
  logic [4:0] stage_done_b = '0;
  logic [4:0] stage_start_b, round_b;
  logic       src_b, dst_b, busy_b, done_b, err_b;
  logic [2:0] state_b;

  encoder_sequencer #(.NUM_ROUNDS(2), .TIMEOUT_CYC(8)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .stage_done(stage_done_a),
    .stage_start(stage_start_a), .round(round_a), .src_sel(src_a), .dst_sel(dst_a),
    .busy(busy_a), .done(done_a), .err(err_a), .dbg_state(state_a)
  );

  encoder_sequencer u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .stage_done(stage_done_b),
    .stage_start(stage_start_b), .round(round_b), .src_sel(src_b), .dst_sel(dst_b),
    .busy(busy_b), .done(done_b), .err(err_b), .dbg_state(state_b)
  );

  // ---------------- stage responders / monitors ----------------
  int         resp_delay = 1;       // WAIT cycle in which stage_done is returned
  logic [4:0] skip_mask  = '0;      // stage that never answers
  bit         noise_en   = 1'b0;    // drive stage_done[3] while stage 1 is pending
  bit         pend_a     = 1'b0;
  int         pend_cnt_a = 0;
  logic [4:0] pend_idx_a = '0;

  logic [4:0] obs_q[$];
  logic [4:0] exp_q[$];
  int done_cnt_a = 0;
  int err_cyc_a  = 0;

  always @(negedge clk) begin
    stage_done_a = '0;
    if (stage_start_a != 5'd0) begin
      pend_a     = 1'b1;
      pend_cnt_a = 0;
      pend_idx_a = stage_start_a;
      obs_q.push_back(stage_start_a);
    end else if (pend_a) begin
      pend_cnt_a++;
      if (noise_en && pend_idx_a == 5'b00010) stage_done_a = 5'b01000;
      if (pend_cnt_a == resp_delay) begin
        pend_a = 1'b0;
        if (pend_idx_a != skip_mask) stage_done_a = stage_done_a | pend_idx_a;
      end
    end
    if (done_a) done_cnt_a++;
    if (err_a) err_cyc_a++;
  end

  logic [4:0] prev_b = '0;
  logic       src_prev_b = 1'b0;
  int ss_cnt_b = 0;
  int tog_b    = 0;

  always @(negedge clk) begin
    stage_done_b = prev_b;
    prev_b = stage_start_b;
    if (stage_start_b != 5'd0) ss_cnt_b++;
    if (src_b !== src_prev_b) tog_b++;
    src_prev_b = src_b;
  end

  // ---------------- checking / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge (count 1).
  task automatic start_pulse(input bit use_b);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // which: 0 done_a, 1 err_a, 2 done_b. lat = clock count after start, -1 on timeout.
  task automatic wait_for(input int which, input bit mid_start, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      if ((which == 0 && done_a) || (which == 1 && err_a) || (which == 2 && done_b)) begin
        lat = k;
        break;
      end
      start_a = (mid_start && k == 20);
      @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk(tag, obs_q[i], exp_q[i]);
  endtask

  // ---------------- main sequence ----------------
  int lat;
  int done_before;

  initial begin
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 5; s++) exp_q.push_back(5'b00001 << s);

    repeat (3) @(negedge clk);
    chk("rst_stage_start", stage_start_a, 5'd0);
    chk("rst_round", round_a, 5'd0);
    chk("rst_src", src_a, 1'b0);
    chk("rst_dst", dst_a, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_state", state_a, 3'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    // two rounds, every stage answers in its first WAIT cycle
    obs_q.delete();
    start_pulse(1'b0);
    chk("launch_first", stage_start_a, 5'b00001);
    chk("launch_busy", busy_a, 1'b1);
    wait_for(0, 1'b0, 200, lat);
    chk("lat_immediate", lat, 31);
    chk("done_round", round_a, 5'd1);
    chk("done_src", src_a, 1'b0);
    chk("done_dst", dst_a, 1'b1);
    chk("done_busy", busy_a, 1'b1);
    @(negedge clk);
    chk("after_done_pulse", done_a, 1'b0);
    chk("after_done_busy", busy_a, 1'b0);
    chk("after_done_round_hold", round_a, 5'd1);
    chk("after_done_state", state_a, 3'd0);
    chk_seq("seq_immediate");

    // slower stages, foreign stage_done while waiting on stage 1, start mid-job
    obs_q.delete();
    resp_delay  = 3;
    noise_en    = 1'b1;
    done_before = done_cnt_a;
    start_pulse(1'b0);
    wait_for(0, 1'b1, 200, lat);
    chk("lat_noise", lat, 51);
    @(negedge clk);
    chk_seq("seq_noise");
    chk("noise_done_count", done_cnt_a - done_before, 1);
    noise_en = 1'b0;

    // stage 2 never answers: timeout after 8 WAIT cycles
    obs_q.delete();
    resp_delay = 1;
    skip_mask  = 5'b00100;
    start_pulse(1'b0);
    wait_for(1, 1'b0, 200, lat);
    chk("lat_fault", lat, 16);
    chk("fault_busy", busy_a, 1'b0);
    chk("fault_stage_start", stage_start_a, 5'd0);
    chk("fault_state", state_a, 3'd5);
    chk("fault_launches", obs_q.size(), 3);
    skip_mask = '0;
    start_pulse(1'b0);
    chk("clear_err", err_a, 1'b0);
    chk("clear_busy", busy_a, 1'b0);
    chk("clear_state", state_a, 3'd0);
    chk("clear_no_launch", stage_start_a, 5'd0);
    obs_q.delete();
    start_pulse(1'b0);
    chk("restart_launch", stage_start_a, 5'b00001);
    chk("restart_round", round_a, 5'd0);
    chk("restart_src", src_a, 1'b0);
    wait_for(0, 1'b0, 200, lat);
    chk("lat_restart", lat, 31);
    @(negedge clk);
    chk_seq("seq_restart");

    // completion in the 8th WAIT cycle wins over the timeout
    resp_delay = 8;
    err_cyc_a  = 0;
    start_pulse(1'b0);
    wait_for(0, 1'b0, 300, lat);
    chk("lat_edge_timeout", lat, 101);
    @(negedge clk);
    chk("edge_timeout_err", err_cyc_a, 0);

    // reset during round 1 stage 3, with start held high on the reset edge
    resp_delay = 1;
    obs_q.delete();
    start_pulse(1'b0);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (round_a == 5'd1 && stage_start_a == 5'b01000) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk("reach_r1s3", lat, 25);
    done_before = done_cnt_a;
    rst_a   = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    rst_a   = 1'b1;
    start_a = 1'b0;
    chk("mid_rst_stage_start", stage_start_a, 5'd0);
    chk("mid_rst_round", round_a, 5'd0);
    chk("mid_rst_src", src_a, 1'b0);
    chk("mid_rst_dst", dst_a, 1'b1);
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_done", done_a, 1'b0);
    chk("mid_rst_err", err_a, 1'b0);
    chk("mid_rst_state", state_a, 3'd0);
    lat = obs_q.size();
    repeat (6) @(negedge clk);
    chk("mid_rst_no_done", done_cnt_a - done_before, 0);
    chk("mid_rst_no_launch", obs_q.size(), lat);
    chk("mid_rst_idle", state_a, 3'd0);

    // default parameters, immediate responses
    ss_cnt_b = 0;
    tog_b    = 0;
    start_pulse(1'b1);
    wait_for(2, 1'b0, 600, lat);
    chk("lat_default", lat, 361);
    chk("default_round", round_b, 5'd23);
    chk("default_src", src_b, 1'b0);
    chk("default_err", err_b, 1'b0);
    @(negedge clk);
    chk("default_launches", ss_cnt_b, 120);
    chk("default_toggles", tog_b, 120);
    chk("default_idle", busy_b, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
